// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - result FIFO broadcasting oldest-first on the common data bus
// Optional same-cycle bypass into idle bus lanes: define CDB_BYPASS_EN.

`ifndef WAY
`define WAY 2
`endif

typedef struct packed {
  logic        valid;
  logic [4:0]  rob_index;
  logic [31:0] result;
} result_packet_t;

module cdb_arbiter #(
  parameter int IN_WIDTH  = 2*`WAY,
  parameter int CDB_WIDTH = `WAY,
  parameter int DEPTH     = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  result_packet_t [IN_WIDTH-1:0]     result_in,
  output result_packet_t [CDB_WIDTH-1:0]    cdb,
  output logic [$clog2(DEPTH+1)-1:0]        free_slots,
  output logic                              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

`ifdef CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  result_packet_t   entry_q [DEPTH];
  result_packet_t   entry_d [DEPTH];

  logic [CNT_W-1:0] deq_n;
  int               enq_n;
  int               bus_slot;
  int               cap;

  assign free_slots = CNT_W'(DEPTH) - count_q;

  always_comb begin
    deq_n    = (count_q < CNT_W'(CDB_WIDTH)) ? count_q : CNT_W'(CDB_WIDTH);
    entry_d  = entry_q;
    cdb      = '0;
    overflow = 1'b0;
    enq_n    = 0;
    bus_slot = int'(deq_n);
    // Capacity uses the start-of-cycle count; slots freed by this cycle's dequeue wait a cycle.
    cap      = DEPTH - int'(count_q);

    for (int i = 0; i < CDB_WIDTH; i++) begin
      if (CNT_W'(i) < deq_n) begin
        cdb[i] = entry_q[head_q + PTR_W'(i)];
      end
    end

    for (int j = 0; j < IN_WIDTH; j++) begin
      if (result_in[j].valid) begin
        if (BYPASS && bus_slot < CDB_WIDTH) begin
          for (int i = 0; i < CDB_WIDTH; i++) begin
            if (i == bus_slot) begin
              cdb[i] = result_in[j];
            end
          end
          bus_slot = bus_slot + 1;
        end else if (enq_n < cap) begin
          entry_d[tail_q + PTR_W'(enq_n)] = result_in[j];
          enq_n = enq_n + 1;
        end else begin
          overflow = 1'b1;
        end
      end
    end

    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q - deq_n + CNT_W'(enq_n);

    if (flush || reset) begin
      cdb      = '0;
      overflow = 1'b0;
      entry_d  = entry_q;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    entry_q <= entry_d;
  end

endmodule
